// File: rtl/enc_pb_pkg.sv
// enc_pb_pkg: shared types and helpers for the encoder/pushbutton bank.
//   step_t      signed 2-bit quadrature step (-1, 0, +1)
//   qdec_step() x4 quadrature decode of previous/current {B,A}
//   sat_add()   signed add of a step with clamping to a given width
package enc_pb_pkg;

  typedef logic signed [1:0] step_t;

  // Position of a {B,A} pair along the clockwise cycle 00->01->11->10.
  function automatic logic [1:0] qdec_pos(input logic [1:0] ba);
    logic [1:0] pos;
    case (ba)
      2'b00:   pos = 2'd0;
      2'b01:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return pos;
  endfunction

  // One position forward is +1 and one back is -1. Two positions apart
  // (both bits flipped) is illegal and counts as no movement.
  function automatic step_t qdec_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] diff;
    step_t      s;
    diff = qdec_pos(cur) - qdec_pos(prev);
    case (diff)
      2'd1:    s = 2'sb01;
      2'd3:    s = 2'sb11;
      default: s = 2'sb00;
    endcase
    return s;
  endfunction

  // a + s clamped to the signed range of a w-bit value (w in 2..31).
  // The result is returned 32 bits wide; the caller truncates to w bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input step_t s,
                                                 input int w);
    logic signed [31:0] s_ext;
    logic signed [31:0] sum;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s_ext = {{30{s[1]}}, s};
    hi    = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo    = -(32'sd1 <<< (w - 1));
    sum   = a + s_ext;
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/deb_bit.sv
// deb_bit: single-bit synchroniser followed by a DEB_N-sample debouncer.
//   clk_i   core clock
//   rst_i   asynchronous active-high reset
//   tick_i  shared sample strobe from the top-level prescaler
//   d_i     raw asynchronous input
//   q_o     debounced level (registered)
// All state resets to RST_VAL so an idle input produces no edge at startup.
module deb_bit #(
  parameter int   SYNC_W  = 2,
  parameter int   DEB_N   = 4,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_W-1:0] sync_q;
  logic [DEB_N-1:0]  hist_q;
  logic [DEB_N-1:0]  hist_d;
  logic              level_q;
  logic              level_d;

  // The level moves only when every retained sample agrees and differs
  // from the current level, so a glitch shorter than DEB_N ticks is ignored.
  always_comb begin
    hist_d  = hist_q;
    level_d = level_q;
    if (tick_i) begin
      hist_d = {hist_q[DEB_N-2:0], sync_q[SYNC_W-1]};
      if ((hist_d == {DEB_N{hist_d[0]}}) && (hist_d[0] != level_q)) begin
        level_d = hist_d[0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_W{RST_VAL}};
      hist_q  <= {DEB_N{RST_VAL}};
      level_q <= RST_VAL;
    end else begin
      sync_q  <= {sync_q[SYNC_W-2:0], d_i};
      hist_q  <= hist_d;
      level_q <= level_d;
    end
  end

  assign q_o = level_q;

endmodule

// File: rtl/enc_pb_bank.sv
// enc_pb_bank: synchronise/debounce CHANNELS quadrature encoders and
// pushbuttons, accumulate saturating signed detent deltas and latch
// sticky press events for software to read and clear.
//   clk_i    core clock
//   rst_i    asynchronous active-high reset
//   enc_i    raw encoder pins, {B,A} per channel, idle high
//   pb_i     raw pushbuttons, active low
//   sel_i    channel select for reads
//   rd_i     read-and-clear strobe
//   delta_o  signed delta of the channel captured by the last read
//   press_o  press flag of the channel captured by the last read
//   pb_o     debounced button levels, 1 = pressed
//   irq_o    any nonzero counter or any set press flag
//
// Read protocol: rd_i is a single-cycle strobe with no back-pressure.
// At the edge where rd_i is high, delta_o/press_o capture the selected
// channel and that channel restarts from whatever step/edge lands in the
// same cycle. The outputs are valid the cycle after and hold until the
// next strobe. A select beyond the last channel reads 0/0, clears nothing.
module enc_pb_bank
  import enc_pb_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int SYNC_W   = 2,
  parameter int DIV      = 50000,
  parameter int DEB_N    = 4,
  parameter int CNT_W    = 8
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic [2*CHANNELS-1:0]                             enc_i,
  input  logic [CHANNELS-1:0]                               pb_i,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel_i,
  input  logic                                              rd_i,
  output logic signed [CNT_W-1:0]                           delta_o,
  output logic                                              press_o,
  output logic [CHANNELS-1:0]                               pb_o,
  output logic                                              irq_o
);

  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PRIME_W = $clog2(DEB_N + 1);

  // ---------------------------------------------------------------------
  // Shared sample prescaler
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick;

  assign tick  = (div_q == DIV_W'(DIV - 1));
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  // ---------------------------------------------------------------------
  // Priming: counts the first DEB_N ticks after reset. primed_q lags the
  // count by one cycle so the previous-level registers have caught up with
  // the settled debounced levels before any step or edge is accepted.
  // ---------------------------------------------------------------------
  logic [PRIME_W-1:0] prime_q;
  logic               primed_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q    <= '0;
      prime_q  <= '0;
      primed_q <= 1'b0;
    end else begin
      div_q <= div_d;
      if (tick && (prime_q != PRIME_W'(DEB_N))) begin
        prime_q <= prime_q + PRIME_W'(1);
      end
      primed_q <= (prime_q == PRIME_W'(DEB_N));
    end
  end

  // ---------------------------------------------------------------------
  // Debouncers: encoders rest high, buttons are inverted so that 1 means
  // pressed and the released state resets to 0.
  // ---------------------------------------------------------------------
  logic [2*CHANNELS-1:0] enc_deb;
  logic [CHANNELS-1:0]   pb_deb;

  for (genvar b = 0; b < 2 * CHANNELS; b++) begin : g_enc_deb
    deb_bit #(
      .SYNC_W (SYNC_W),
      .DEB_N  (DEB_N),
      .RST_VAL(1'b1)
    ) u_deb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .tick_i(tick),
      .d_i   (enc_i[b]),
      .q_o   (enc_deb[b])
    );
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_pb_deb
    deb_bit #(
      .SYNC_W (SYNC_W),
      .DEB_N  (DEB_N),
      .RST_VAL(1'b0)
    ) u_deb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .tick_i(tick),
      .d_i   (~pb_i[c]),
      .q_o   (pb_deb[c])
    );
  end

  // ---------------------------------------------------------------------
  // Decode, counters, press flags and read mux
  // ---------------------------------------------------------------------
  logic [2*CHANNELS-1:0]   enc_prev_q;
  logic [CHANNELS-1:0]     pb_prev_q;
  logic signed [CNT_W-1:0] cnt_q [CHANNELS];
  logic signed [CNT_W-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]     press_q;
  logic [CHANNELS-1:0]     press_d;
  step_t                   step   [CHANNELS];
  logic [CHANNELS-1:0]     pb_edge;
  logic                    rd_hit;
  logic signed [CNT_W-1:0] rd_delta;
  logic                    rd_press;
  logic signed [CNT_W-1:0] delta_q;
  logic                    press_out_q;
  logic                    irq_c;

  assign rd_hit = (int'(sel_i) < CHANNELS);

  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      step[ch]    = 2'sb00;
      pb_edge[ch] = 1'b0;
      cnt_d[ch]   = cnt_q[ch];
      press_d[ch] = press_q[ch];
      if (primed_q) begin
        step[ch]    = qdec_step(enc_prev_q[2*ch +: 2], enc_deb[2*ch +: 2]);
        pb_edge[ch] = pb_deb[ch] & ~pb_prev_q[ch];
      end
      // A read restarts the window from this cycle's step/edge, so an
      // event coinciding with the read lands in the next window.
      if (rd_i && rd_hit && (int'(sel_i) == ch)) begin
        cnt_d[ch]   = CNT_W'(step[ch]);
        press_d[ch] = pb_edge[ch];
      end else begin
        cnt_d[ch]   = CNT_W'(sat_add(32'(cnt_q[ch]), step[ch], CNT_W));
        press_d[ch] = press_q[ch] | pb_edge[ch];
      end
    end
  end

  always_comb begin
    rd_delta = '0;
    rd_press = 1'b0;
    if (rd_hit) begin
      rd_delta = cnt_q[sel_i];
      rd_press = press_q[sel_i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enc_prev_q  <= '1;
      pb_prev_q   <= '0;
      press_q     <= '0;
      delta_q     <= '0;
      press_out_q <= 1'b0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      // Previous levels follow the debouncers even while priming, so the
      // resting position is absorbed without producing a count.
      enc_prev_q <= enc_deb;
      pb_prev_q  <= pb_deb;
      press_q    <= press_d;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
      if (rd_i) begin
        delta_q     <= rd_delta;
        press_out_q <= rd_press;
      end
    end
  end

  always_comb begin
    irq_c = |press_q;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (cnt_q[ch] != '0) begin
        irq_c = 1'b1;
      end
    end
  end

  assign delta_o = delta_q;
  assign press_o = press_out_q;
  assign pb_o    = pb_deb;
  assign irq_o   = irq_c;

endmodule

// File: tb/tb_enc_pb_bank.sv
// tb_enc_pb_bank: directed bench for enc_pb_bank with a read scoreboard.
// Small DIV/DEB_N keep runs short; CNT_W=5 gives a -16..+15 range so both
// saturation limits are reachable with short rotations.
module tb_enc_pb_bank;

  localparam int CH = 8;
  localparam int SW = 2;
  localparam int DV = 4;
  localparam int DN = 2;
  localparam int CW = 5;
  // Pin change to counter update is at most SW + DN*DV + 1 cycles.
  localparam int SETTLE = 14;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [2*CH-1:0]      enc_i;
  logic [CH-1:0]        pb_i;
  logic [2:0]           sel_i;
  logic                 rd_i;
  logic signed [CW-1:0] delta_o;
  logic                 press_o;
  logic [CH-1:0]        pb_o;
  logic                 irq_o;

  always #5 clk = ~clk;

  // Posedges since reset release; the DUT prescaler ticks on every 4th.
  int edge_n;
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  enc_pb_bank #(
    .CHANNELS(CH),
    .SYNC_W  (SW),
    .DIV     (DV),
    .DEB_N   (DN),
    .CNT_W   (CW)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .enc_i  (enc_i),
    .pb_i   (pb_i),
    .sel_i  (sel_i),
    .rd_i   (rd_i),
    .delta_o(delta_o),
    .press_o(press_o),
    .pb_o   (pb_o),
    .irq_o  (irq_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Scoreboard and model
  // ---------------------------------------------------------------------
  logic [CW:0] exp_q[$];
  int          tests_run = 0;
  int          fails = 0;
  int          mdl_cnt   [CH];
  bit          mdl_press [CH];
  int          pos       [CH];
  logic [1:0]  gray_tab  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int sat(input int v);
    int hi;
    int lo;
    hi = (1 << (CW - 1)) - 1;
    lo = -(1 << (CW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      mdl_cnt[c]   = 0;
      mdl_press[c] = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks (all start and end on a negedge)
  // ---------------------------------------------------------------------
  task automatic set_enc(input int ch);
    enc_i[2*ch +: 2] = gray_tab[pos[ch]];
  endtask

  task automatic enc_move(input int ch, input int dir, input int n);
    for (int i = 0; i < n; i++) begin
      pos[ch] = (pos[ch] + dir + 4) % 4;
      set_enc(ch);
      mdl_cnt[ch] = sat(mdl_cnt[ch] + dir);
      repeat (SETTLE) @(negedge clk);
    end
  endtask

  task automatic push_exp(input int ch);
    logic [CW-1:0] d;
    d = CW'(mdl_cnt[ch]);
    exp_q.push_back({mdl_press[ch], d});
    mdl_cnt[ch]   = 0;
    mdl_press[ch] = 1'b0;
  endtask

  task automatic pop_chk(input int ch);
    logic [CW:0] e;
    if (exp_q.size() == 0) begin
      chk($sformatf("sb_empty ch%0d", ch), 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("delta ch%0d", ch), $signed(delta_o), $signed(e[CW-1:0]));
      chk($sformatf("press ch%0d", ch), {31'b0, press_o}, {31'b0, e[CW]});
    end
  endtask

  task automatic do_read(input int ch);
    push_exp(ch);
    sel_i = 3'(ch);
    rd_i  = 1'b1;
    @(negedge clk);
    rd_i  = 1'b0;
    pop_chk(ch);
  endtask

  task automatic read_b2b(input int a, input int b);
    push_exp(a);
    sel_i = 3'(a);
    rd_i  = 1'b1;
    @(negedge clk);
    pop_chk(a);
    push_exp(b);
    sel_i = 3'(b);
    @(negedge clk);
    rd_i  = 1'b0;
    pop_chk(b);
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    int guard;
    rst_i = 1'b1;
    enc_i = '1;
    pb_i  = '1;
    sel_i = '0;
    rd_i  = 1'b0;
    for (int c = 0; c < CH; c++) pos[c] = 2;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst delta_o", $signed(delta_o), 0);
    chk("rst press_o", {31'b0, press_o}, 0);
    chk("rst irq_o", {31'b0, irq_o}, 0);
    chk("rst pb_o", {24'b0, pb_o}, 0);
    rst_i = 1'b0;

    // Idle for 10 ticks
    repeat (10 * DV) @(negedge clk);
    chk("idle irq_o", {31'b0, irq_o}, 0);
    do_read(0);

    // Three CW cycles on ch3
    enc_move(3, 1, 12);
    chk("ch3 irq before read", {31'b0, irq_o}, 1);
    do_read(3);
    chk("ch3 irq after read", {31'b0, irq_o}, 0);

    // 20 CCW on ch1 saturates low; back-to-back second read sees 0
    enc_move(1, -1, 20);
    read_b2b(1, 1);

    // 18 CW on ch0 saturates high
    enc_move(0, 1, 18);
    do_read(0);

    // Button ch5: one-tick glitch is rejected, then a real press
    pb_i[5] = 1'b0;
    repeat (DV) @(negedge clk);
    pb_i[5] = 1'b1;
    repeat (SETTLE) @(negedge clk);
    chk("glitch pb_o5", {31'b0, pb_o[5]}, 0);
    chk("glitch irq_o", {31'b0, irq_o}, 0);
    pb_i[5] = 1'b0;
    mdl_press[5] = 1'b1;
    repeat (3 * DV + SETTLE) @(negedge clk);
    chk("held pb_o5", {31'b0, pb_o[5]}, 1);
    chk("press irq_o", {31'b0, irq_o}, 1);
    do_read(5);
    chk("held pb_o5 after read", {31'b0, pb_o[5]}, 1);
    pb_i[5] = 1'b1;
    repeat (SETTLE) @(negedge clk);
    chk("released pb_o5", {31'b0, pb_o[5]}, 0);
    do_read(5);

    // CW step on ch2 landing in the same cycle as its read
    enc_move(2, 1, 5);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((edge_n % DV != 0) && (guard < 16));
    chk("tick align", {31'b0, guard < 16}, 1);
    pos[2] = (pos[2] + 1) % 4;
    set_enc(2);
    // Sync (2) then two tick samples put the step on the 9th edge.
    repeat (8) @(negedge clk);
    do_read(2);
    mdl_cnt[2] = 1;
    repeat (SETTLE) @(negedge clk);
    chk("ch2 carry irq", {31'b0, irq_o}, 1);
    do_read(2);

    // Mid-operation reset, ch4 held at 01 through reset release
    enc_move(6, 1, 2);
    chk("ch6 irq", {31'b0, irq_o}, 1);
    pos[4] = 1;
    set_enc(4);
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("async rst irq_o", {31'b0, irq_o}, 0);
    chk("async rst delta_o", $signed(delta_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (10 * DV) @(negedge clk);
    chk("primed irq_o", {31'b0, irq_o}, 0);
    do_read(4);
    do_read(6);
    do_read(0);
    enc_move(4, 1, 1);
    do_read(4);

    chk("sb drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
